cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Controller stage directly upstream of the datapath: holds the 16-bit instruction register, decodes the instruction and steps a Moore state machine that drives every datapath control strobe. It also drives the register selects and the sign-extended immediates. It handles MOV-immediate, MOV-register, ADD, CMP, AND and MVN, one instruction at a time, started by `s` and reporting idle on `w`.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `in` in 16: instruction word
- `load` in 1: instruction register load enable
- `s` in 1: start execution of the instruction in IR
- `w` out 1: 1 = waiting/idle
- `halted` out 1: 1 = parked in HALT (tied 0 unless the macro is defined)
- `readnum`, `writenum` out 3: register-file read/write selects
- `vsel` out 2: write-back source; 00 = ALU result, 10 = sximm8
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1: datapath strobes
- `asel`, `bsel` out 1: operand selects; asel=1 means A=0, bsel=1 means B=sximm5
- `shift` out 2: IR[4:3]
- `ALUop` out 2: IR[12:11]
- `sximm5` out 16: IR[4:0] sign-extended
- `sximm8` out 16: IR[7:0] sign-extended

## Operation
- Field layout: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
- Supported encodings:
  - 110/10: MOV Rn,#im8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD
  - 101/01: CMP
  - 101/10: AND
  - 101/11: MVN
- IR captures `in` on a clock edge with `load`=1, only while in WAIT. `load` is ignored in every other state, so the in-flight instruction stays stable.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, CMP, WRITE_REG, plus HALT (macro only).
- Transitions:
  - WAIT: to DECODE when `s`=1, else stay.
  - DECODE by instruction:
    - MOV-imm: to WRITE_IMM.
    - ADD, AND, CMP: to GET_A.
    - MOV-reg, MVN: to GET_B.
    - Any other encoding: to WAIT, with no strobe asserted.
  - WRITE_IMM: to WAIT.
  - GET_A: to GET_B.
  - GET_B: to CMP for CMP, else to ALU.
  - ALU: to WRITE_REG.
  - WRITE_REG: to WAIT.
  - CMP: to WAIT.
- Outputs per state (all strobes 0 unless listed):
  - WAIT: `w`=1.
  - WRITE_IMM: `write`=1, `vsel`=10, `writenum`=Rn.
  - GET_A: `loada`=1, `readnum`=Rn.
  - GET_B: `loadb`=1, `readnum`=Rm.
  - ALU: `loadc`=1, `bsel`=0; `asel`=1 for MOV-reg/MVN, else 0.
  - CMP: `loads`=1, `asel`=0, `bsel`=0.
  - WRITE_REG: `write`=1, `vsel`=00, `writenum`=Rd.
- Default selects: `readnum` = `writenum` = Rn, `vsel`=00, `asel`=`bsel`=0.
- `ALUop`, `shift`, `sximm5` and `sximm8` are combinational from IR in every state.
- `s` is sampled only in WAIT. `s` held high re-starts the same IR on the edge after the return to WAIT.

## Timing
- Outputs are decoded from the state register only (Moore); no output path from `s`, `load` or `in`.
- Edges counted from the edge that samples `s`=1 until `w`=1 again:
  - MOV-imm: 2
  - ADD/AND: 5
  - CMP: 4
  - MOV-reg/MVN: 4
  - Illegal encoding: 1
- Each strobe is high for exactly one cycle per instruction.
- Reset: `rst_n`=0 immediately forces WAIT and IR=0. Then `w`=1, `halted`=0, all strobes 0, `readnum`=`writenum`=0, `vsel`=00, `sximm5`=`sximm8`=0.
- Reset asserted mid-instruction aborts it: no `write` or `loads` pulse follows. Release is recognised on the next rising edge.

## Configuration
- `CPU_CTRL_HALT_EN` defined:
  - Opcode 111 decodes to HALT; DECODE goes to HALT.
  - HALT holds with `w`=0, `halted`=1 and all strobes 0.
  - `s` and `load` are ignored in HALT; only `rst_n` leaves it.
- Undefined: opcode 111 is illegal (DECODE to WAIT) and `halted` is constant 0.

## Test plan
- Reset: pulse `rst_n`=0 mid-ALU state of an ADD -> same cycle `w`=1, all strobes 0; no `write` at any later edge; IR=0.
- MOV R3,#-2: `in`=16'hD3FE, `load`, `s` -> WRITE_IMM with `write`=1, `writenum`=3, `vsel`=10, `sximm8`=16'hFFFE; `w`=1 two edges after `s`.
- ADD R2,R1,R0,LSL#1: `in`=16'hA148 -> strobes in order:
  - `loada` with `readnum`=1
  - `loadb` with `readnum`=0
  - `loadc` with `asel`=0
  - `write` with `writenum`=2, `vsel`=00
  - throughout: `shift`=01, `ALUop`=00; `w`=1 after 5 edges.
- CMP R4,R5: `in`=16'hAC05 -> `loads`=1 for exactly one cycle, `write` never 1, `w`=1 after 4 edges.
- IR protection: during GET_A of MVN R1,R7 (16'hB827), `load`=1 with `in`=16'hD0FF -> IR still 16'hB827; `asel`=1 in ALU state; `write` with `writenum`=1.
- HALT (macro defined): `in`=16'hE000, `s` -> `halted`=1, `w`=0 from the second edge onward; further `s`/`load` have no effect until `rst_n`=0. Macro undefined: `w`=1 after 1 edge.

Source files
------------

// File: rtl/cpu_ctrl.sv
// Purpose : instruction register, decoder and Moore sequencer driving the datapath strobes.
// Latency : edges from the edge sampling s=1 to w=1: MOV-imm 2, ADD/AND 5, CMP 4, MOV-reg/MVN 4, illegal 1.
// Backpres: none; one instruction in flight, s is sampled only while idle (w=1), load only while idle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (forces WAIT and clears IR)
//   in, load              instruction word and IR load enable (honoured in WAIT only)
//   s, w, halted          start request, idle indication, parked-in-HALT indication
//   readnum, writenum     register file read/write selects
//   vsel                  write-back source (00 ALU result, 10 sximm8)
//   loada/b/c, loads, write, asel, bsel   datapath strobes and operand selects
//   shift, ALUop, sximm5, sximm8          fields taken straight from IR
//
// Optional feature macro: CPU_CTRL_HALT_EN (opcode 111 parks the sequencer in HALT until reset).

module cpu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        halted,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [3:0] {
        S_WAIT      = 4'd0,
        S_DECODE    = 4'd1,
        S_WRITE_IMM = 4'd2,
        S_GET_A     = 4'd3,
        S_GET_B     = 4'd4,
        S_ALU       = 4'd5,
        S_CMP       = 4'd6,
        S_WRITE_REG = 4'd7,
        S_HALT      = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign shift  = ir[4:3];
    assign ALUop  = ir[12:11];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;
    logic uses_a;      // ADD, AND, CMP read Rn into A
    logic zero_a;      // MOV-reg and MVN feed the ALU with A forced to 0

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign uses_a     = is_alu && !is_mvn;
    assign zero_a     = is_mov_reg || is_mvn;

`ifdef CPU_CTRL_HALT_EN
    logic is_halt;
    assign is_halt = (opcode == 3'b111);
`endif

    // IR only moves while idle so the executing instruction cannot change under the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if ((state == S_WAIT) && load) begin
                ir <= in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        halted    = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        readnum   = rn;
        writenum  = rn;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_nxt = S_WRITE_IMM;
                end else if (uses_a) begin
                    state_nxt = S_GET_A;
                end else if (zero_a) begin
                    state_nxt = S_GET_B;
`ifdef CPU_CTRL_HALT_EN
                end else if (is_halt) begin
                    state_nxt = S_HALT;
`endif
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                write     = 1'b1;
                vsel      = 2'b10;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                loadb     = 1'b1;
                readnum   = rm;
                state_nxt = is_cmp ? S_CMP : S_ALU;
            end
            S_ALU: begin
                loadc     = 1'b1;
                asel      = zero_a;
                state_nxt = S_WRITE_REG;
            end
            S_CMP: begin
                loads     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WRITE_REG: begin
                write     = 1'b1;
                writenum  = rd;
                state_nxt = S_WAIT;
            end
`ifdef CPU_CTRL_HALT_EN
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
`endif
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        load;
    logic        s;
    logic        w;
    logic        halted;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    int vectors     = 0;
    int miscompares = 0;

    cpu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (instr),
        .load     (load),
        .s        (s),
        .w        (w),
        .halted   (halted),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Every observable output of the controller for one cycle.
    typedef struct packed {
        logic        w;
        logic        halted;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } outs_t;

    outs_t exp_q[$];

    function automatic outs_t snap();
        outs_t o;
        o.w        = w;
        o.halted   = halted;
        o.loada    = loada;
        o.loadb    = loadb;
        o.loadc    = loadc;
        o.loads    = loads;
        o.write    = write;
        o.asel     = asel;
        o.bsel     = bsel;
        o.vsel     = vsel;
        o.readnum  = readnum;
        o.writenum = writenum;
        o.shift    = shift;
        o.aluop    = ALUop;
        o.sximm5   = sximm5;
        o.sximm8   = sximm8;
        return o;
    endfunction

    // Quiet cycle for a given IR: no strobes, selects on Rn, fields from IR.
    function automatic outs_t base(input logic [15:0] ir_v, input logic w_v);
        outs_t o;
        int    v5;
        int    v8;
        o          = '0;
        o.w        = w_v;
        o.readnum  = ir_v[10:8];
        o.writenum = ir_v[10:8];
        o.shift    = ir_v[4:3];
        o.aluop    = ir_v[12:11];
        v5         = int'(ir_v[4:0]);
        v8         = int'(ir_v[7:0]);
        if (v5 >= 16) v5 = v5 - 32;
        if (v8 >= 128) v8 = v8 - 256;
        o.sximm5   = 16'(v5);
        o.sximm8   = 16'(v8);
        return o;
    endfunction

    // Expected cycle-by-cycle program of one instruction: DECODE, its strobe steps, back in WAIT.
    task automatic build(input logic [15:0] ir_v);
        outs_t b;
        outs_t r;
        exp_q.delete();
        b = base(ir_v, 1'b0);
        exp_q.push_back(b);
        case ({ir_v[15:13], ir_v[12:11]})
            5'b110_10: begin
                r = b; r.write = 1'b1; r.vsel = 2'b10; r.writenum = ir_v[10:8]; exp_q.push_back(r);
            end
            5'b101_00, 5'b101_10: begin
                r = b; r.loada = 1'b1; r.readnum = ir_v[10:8]; exp_q.push_back(r);
                r = b; r.loadb = 1'b1; r.readnum = ir_v[2:0];  exp_q.push_back(r);
                r = b; r.loadc = 1'b1;                        exp_q.push_back(r);
                r = b; r.write = 1'b1; r.writenum = ir_v[7:5]; exp_q.push_back(r);
            end
            5'b101_01: begin
                r = b; r.loada = 1'b1; r.readnum = ir_v[10:8]; exp_q.push_back(r);
                r = b; r.loadb = 1'b1; r.readnum = ir_v[2:0];  exp_q.push_back(r);
                r = b; r.loads = 1'b1;                        exp_q.push_back(r);
            end
            5'b110_00, 5'b101_11: begin
                r = b; r.loadb = 1'b1; r.readnum = ir_v[2:0];  exp_q.push_back(r);
                r = b; r.loadc = 1'b1; r.asel = 1'b1;         exp_q.push_back(r);
                r = b; r.write = 1'b1; r.writenum = ir_v[7:5]; exp_q.push_back(r);
            end
            default: begin
            end
        endcase
        exp_q.push_back(base(ir_v, 1'b1));
    endtask

    task automatic check(input string tag, input outs_t expv);
        outs_t obs;
        obs = snap();
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // noise: 0 quiet inputs, 1 random load/s/in while busy, 2 load=1 with in=16'hD0FF while busy
    task automatic run_instr(input logic [15:0] ir_v, input int noise, input string tag);
        build(ir_v);
        instr = ir_v;
        load  = 1'b1;
        s     = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check(tag, exp_q[i]);
            if (i == exp_q.size() - 1) begin
                load = 1'b0;
                s    = 1'b0;
            end else if (noise == 1) begin
                load  = 1'($urandom);
                s     = 1'($urandom);
                instr = 16'($urandom);
            end else if (noise == 2) begin
                load  = 1'b1;
                s     = 1'b0;
                instr = 16'hD0FF;
            end else begin
                load = 1'b0;
                s    = 1'b0;
            end
        end
    endtask

    initial begin
        outs_t r;
        logic [15:0] rnd;
        rst_n = 1'b0;
        instr = 16'h0000;
        load  = 1'b0;
        s     = 1'b0;

        #1;
        check("reset_state", base(16'h0000, 1'b1));
        step();
        check("reset_held", base(16'h0000, 1'b1));
        rst_n = 1'b1;
        step();
        check("idle_after_release", base(16'h0000, 1'b1));

        run_instr(16'hD3FE, 0, "mov_imm_r3_m2");
        run_instr(16'hA148, 0, "add_r2_r1_r0_lsl1");
        run_instr(16'hAC05, 0, "cmp_r4_r5");
        run_instr(16'hB827, 2, "mvn_r1_r7_ir_protect");
        run_instr(16'hC0E3, 0, "mov_reg");
        run_instr(16'hB0A6, 0, "and");
        run_instr(16'hC834, 0, "illegal_110_01");

        // s held high: the same IR restarts on the edge after returning to WAIT.
        instr = 16'hD3FE; load = 1'b1; s = 1'b1;
        step(); check("hold_s_decode", base(16'hD3FE, 1'b0));
        load = 1'b0;
        step();
        r = base(16'hD3FE, 1'b0); r.write = 1'b1; r.vsel = 2'b10;
        check("hold_s_write_imm", r);
        step(); check("hold_s_wait", base(16'hD3FE, 1'b1));
        step(); check("hold_s_restart", base(16'hD3FE, 1'b0));
        s = 1'b0;
        step(); check("hold_s_write_imm2", r);
        step(); check("hold_s_wait2", base(16'hD3FE, 1'b1));

        // Reset in the ALU cycle of an ADD aborts it with no later write.
        instr = 16'hA148; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        step(); step(); step();
        r = base(16'hA148, 1'b0); r.loadc = 1'b1;
        check("abort_alu_cycle", r);
        rst_n = 1'b0;
        #1;
        check("abort_reset_same_cycle", base(16'h0000, 1'b1));
        step();
        check("abort_reset_held", base(16'h0000, 1'b1));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_write", base(16'h0000, 1'b1));
        end

`ifdef CPU_CTRL_HALT_EN
        instr = 16'hE000; load = 1'b1; s = 1'b1;
        step(); check("halt_decode", base(16'hE000, 1'b0));
        r = base(16'hE000, 1'b0); r.halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load  = 1'b1;
            s     = 1'b1;
            instr = 16'($urandom);
            step();
            check("halt_parked", r);
        end
        load = 1'b0; s = 1'b0;
        rst_n = 1'b0;
        #1;
        check("halt_reset", base(16'h0000, 1'b1));
        step();
        rst_n = 1'b1;
        step();
        check("halt_released", base(16'h0000, 1'b1));
`else
        run_instr(16'hE000, 0, "opcode_111_illegal");
`endif

        for (int n = 0; n < 150; n++) begin
            rnd = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rnd[15:13] = 3'b101;
                4, 5, 6, 7: rnd[15:13] = 3'b110;
                default: begin
                end
            endcase
`ifdef CPU_CTRL_HALT_EN
            if (rnd[15:13] == 3'b111) rnd[15:13] = 3'b000;
`endif
            run_instr(rnd, 1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
